// File: rtl/i2c_txn_arbiter.sv
// Two-requester, per-transaction arbiter in front of the single byte-level BME280 I2C controller port.
// Build option ARB_FIXED_PRIO_EN: requester 0 wins simultaneous requests; otherwise round-robin.
module i2c_txn_arbiter #(
  parameter int                 DWIDTH  = 8,
  parameter int                 TOWIDTH = 16,
  parameter logic [TOWIDTH-1:0] TIMEOUT = 16'd50000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0_start,
  input  logic              Req0_rdwr,
  input  logic              Req0_last,
  input  logic [DWIDTH-1:0] Req0_addr,
  input  logic [DWIDTH-1:0] Req0_txd,
  output logic              Req0_ack,
  output logic              Req0_done,
  input  logic              Req1_start,
  input  logic              Req1_rdwr,
  input  logic              Req1_last,
  input  logic [DWIDTH-1:0] Req1_addr,
  input  logic [DWIDTH-1:0] Req1_txd,
  output logic              Req1_ack,
  output logic              Req1_done,
  output logic [DWIDTH-1:0] Rxd,
  output logic              I2C_start,
  output logic              I2C_rdwr,
  output logic              I2C_last,
  output logic [DWIDTH-1:0] I2C_addr,
  output logic [DWIDTH-1:0] I2C_txd,
  input  logic [DWIDTH-1:0] I2C_rxd,
  input  logic              I2C_done,
  output logic              Owner,
  output logic              Busy,
  output logic              Timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state;
  logic               ptr;
  logic [TOWIDTH-1:0] wd;
  logic               expire;
  logic               grant_vld;
  logic               grant_sel;
  logic               tie_sel;
  logic               next_ptr;
  logic               op_done;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_sel  = 1'b0;
  assign next_ptr = 1'b0;
`else
  assign tie_sel  = ptr;
  assign next_ptr = ~Owner;
`endif

  // Revocation wins over a same-cycle owner request so the lock can never be extended past the limit.
  assign expire = (state == HOLD) && (wd == TIMEOUT - 1'b1);

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (Req0_start && Req1_start) begin
            grant_vld = 1'b1;
            grant_sel = tie_sel;
          end else if (Req0_start || Req1_start) begin
            grant_vld = 1'b1;
            grant_sel = Req1_start;
          end
        end
        HOLD: begin
          grant_sel = Owner;
          grant_vld = !expire && (Owner ? Req1_start : Req0_start);
        end
        default: begin
          grant_vld = 1'b0;
          grant_sel = 1'b0;
        end
      endcase
    end
  end

  assign op_done   = (state == WAIT) && I2C_done;
  assign Req0_ack  = grant_vld && !grant_sel;
  assign Req1_ack  = grant_vld && grant_sel;
  assign Req0_done = op_done && !Owner;
  assign Req1_done = op_done && Owner;
  assign Rxd       = op_done ? I2C_rxd : '0;
  assign Busy      = (state != IDLE);
  assign Timeout   = expire;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      wd        <= '0;
      Owner     <= 1'b0;
      I2C_start <= 1'b0;
      I2C_rdwr  <= 1'b0;
      I2C_last  <= 1'b0;
      I2C_addr  <= '0;
      I2C_txd   <= '0;
    end else begin
      I2C_start <= 1'b0;
      if (grant_vld) begin
        state     <= ISSUE;
        Owner     <= grant_sel;
        I2C_start <= 1'b1;
        I2C_rdwr  <= grant_sel ? Req1_rdwr : Req0_rdwr;
        I2C_last  <= grant_sel ? Req1_last : Req0_last;
        I2C_addr  <= grant_sel ? Req1_addr : Req0_addr;
        I2C_txd   <= grant_sel ? Req1_txd  : Req0_txd;
        wd        <= '0;
      end else begin
        case (state)
          ISSUE: state <= WAIT;
          WAIT: begin
            if (I2C_done) begin
              if (I2C_last) begin
                state <= IDLE;
                ptr   <= next_ptr;
              end else begin
                state <= HOLD;
                wd    <= '0;
              end
            end
          end
          HOLD: begin
            if (expire) begin
              state <= IDLE;
              ptr   <= next_ptr;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: behavioural I2C controller model plus a scoreboard of expected grants and completions.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req0_start, Req0_rdwr, Req0_last, Req0_ack, Req0_done;
  logic [7:0] Req0_addr, Req0_txd;
  logic       Req1_start, Req1_rdwr, Req1_last, Req1_ack, Req1_done;
  logic [7:0] Req1_addr, Req1_txd;
  logic [7:0] Rxd, I2C_addr, I2C_txd, I2C_rxd;
  logic       I2C_start, I2C_rdwr, I2C_last, I2C_done;
  logic       Owner, Busy, Timeout;

  i2c_txn_arbiter #(.DWIDTH(8), .TOWIDTH(16), .TIMEOUT(16'd20)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0_start(Req0_start), .Req0_rdwr(Req0_rdwr), .Req0_last(Req0_last),
    .Req0_addr(Req0_addr), .Req0_txd(Req0_txd), .Req0_ack(Req0_ack), .Req0_done(Req0_done),
    .Req1_start(Req1_start), .Req1_rdwr(Req1_rdwr), .Req1_last(Req1_last),
    .Req1_addr(Req1_addr), .Req1_txd(Req1_txd), .Req1_ack(Req1_ack), .Req1_done(Req1_done),
    .Rxd(Rxd), .I2C_start(I2C_start), .I2C_rdwr(I2C_rdwr), .I2C_last(I2C_last),
    .I2C_addr(I2C_addr), .I2C_txd(I2C_txd), .I2C_rxd(I2C_rxd), .I2C_done(I2C_done),
    .Owner(Owner), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] rxd;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];
  int   own_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stray_cnt = 0;
  int   stray_seen = 0;
  bit   ack1_seen = 1'b0;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'hFA:   rom = 8'h80;
      8'hFB:   rom = 8'h00;
      8'hFC:   rom = 8'h00;
      default: rom = a ^ 8'h3C;
    endcase
  endfunction

  // Controller model: done four cycles after the start cycle; can also inject stray done pulses.
  initial begin
    logic [7:0] a;
    I2C_done = 1'b0;
    I2C_rxd  = '0;
    forever begin
      @(negedge Clk);
      if (I2C_start === 1'b1) begin
        a = I2C_addr;
        repeat (4) @(posedge Clk);
        #1 I2C_done = 1'b1; I2C_rxd = rom(a);
        @(posedge Clk);
        #1 I2C_done = 1'b0; I2C_rxd = '0;
      end else if (stray_cnt != stray_seen) begin
        @(posedge Clk);
        #1 I2C_done = 1'b1; I2C_rxd = 8'h5A;
        @(posedge Clk);
        #1 I2C_done = 1'b0; I2C_rxd = '0;
        stray_seen++;
      end
    end
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int r, input bit s, input bit rw, input bit l, input logic [7:0] a, input logic [7:0] d);
    if (r == 0) begin
      Req0_start = s; Req0_rdwr = rw; Req0_last = l; Req0_addr = a; Req0_txd = d;
    end else begin
      Req1_start = s; Req1_rdwr = rw; Req1_last = l; Req1_addr = a; Req1_txd = d;
    end
  endtask

  task automatic wait_ack(input int budget, output int who, output int at);
    who = -1; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (Req1_ack) ack1_seen = 1'b1;
      if (Req0_ack || Req1_ack) begin
        who = (Req0_ack && Req1_ack) ? 2 : (Req1_ack ? 1 : 0);
        at  = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int who, output logic [7:0] rx, output int at);
    who = -1; at = -1; rx = 'x;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (Req1_ack) ack1_seen = 1'b1;
      if (Req0_done || Req1_done) begin
        who = (Req0_done && Req1_done) ? 2 : (Req1_done ? 1 : 0);
        rx  = Rxd;
        at  = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) @(posedge Clk);
    #2;
    checks++; if ({Busy, Owner, I2C_start, I2C_rdwr, I2C_last, Timeout, Req0_ack, Req1_ack, Req0_done, Req1_done} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {Busy, Owner, I2C_start, I2C_rdwr, I2C_last, Timeout, Req0_ack, Req1_ack, Req0_done, Req1_done}); end
    checks++; if ({I2C_addr, I2C_txd, Rxd} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {I2C_addr, I2C_txd, Rxd}); end
    @(posedge Clk); #1 Rst = 1'b0;
  endtask

  task automatic test_single;
    int who, t, td; logic [7:0] rx; exp_t e;
    step; drive(0, 1, 0, 1, 8'hF4, 8'h27);
    wait_ack(5, who, t);
    checks++; if (who !== 0) begin errors++; $display("FAIL single_ack: got %0d expected 0", who); end
    checks++; if (I2C_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b expected 0", I2C_start); end
    exp_q.push_back('{req: 2'd0, rxd: 8'h00, chk: 1'b0});
    step; drive(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge Clk);
    checks++; if ({I2C_start, I2C_addr, I2C_txd, I2C_rdwr, I2C_last, Owner, Busy} !== {1'b1, 8'hF4, 8'h27, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL single_issue: got %h expected %h", {I2C_start, I2C_addr, I2C_txd, I2C_rdwr, I2C_last, Owner, Busy},
                          {1'b1, 8'hF4, 8'h27, 1'b0, 1'b1, 1'b0, 1'b1}); end
    @(negedge Clk);
    checks++; if (I2C_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", I2C_start); end
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL single_done_who: got %0d expected %0d", who, e.req); end
    checks++; if (td - t !== 5) begin errors++; $display("FAIL single_done_lat: got %0d expected 5", td - t); end
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", Busy); end
  endtask

  task automatic test_lock;
    int who, t, td; logic [7:0] rx, a; exp_t e;
    ack1_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 8'hFA + 8'(k);
      step; drive(0, 1, 1, (k == 2), a, 8'h00);
      wait_ack(30, who, t);
      checks++; if (who !== 0) begin errors++; $display("FAIL lock_ack_%0d: got %0d expected 0", k, who); end
      exp_q.push_back('{req: 2'd0, rxd: rom(a), chk: 1'b1});
      step; drive(0, 0, 0, 0, 8'h00, 8'h00);
      if (k == 0) begin step; drive(1, 1, 0, 1, 8'hF5, 8'hA0); end
      wait_done(30, who, rx, td);
      e = exp_q.pop_front();
      checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL lock_done_who_%0d: got %0d expected %0d", k, who, e.req); end
      checks++; if (rx !== e.rxd) begin errors++; $display("FAIL lock_rxd_%0d: got %h expected %h", k, rx, e.rxd); end
    end
    checks++; if (ack1_seen !== 1'b0) begin errors++; $display("FAIL lock_req1_early: got %b expected 0", ack1_seen); end
    step;
    wait_ack(10, who, t);
    checks++; if (who !== 1 || t !== td + 1) begin errors++; $display("FAIL lock_req1_grant: got who %0d at +%0d expected 1 at +1", who, t - td); end
    exp_q.push_back('{req: 2'd1, rxd: 8'h00, chk: 1'b0});
    step; drive(1, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL lock_req1_done: got %0d expected %0d", who, e.req); end
  endtask

  task automatic test_contention;
    int who, t, td, exp_own; logic [7:0] rx;
`ifdef ARB_FIXED_PRIO_EN
    own_q = '{0, 0, 0, 0};
`else
    own_q = '{0, 1, 0, 1};
`endif
    step; drive(0, 1, 0, 1, 8'h10, 8'h01); drive(1, 1, 0, 1, 8'h20, 8'h02);
    for (int g = 0; g < 4; g++) begin
      wait_ack(30, who, t);
      exp_own = own_q.pop_front();
      checks++; if (who !== exp_own) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", g, who, exp_own); end
      @(negedge Clk);
      checks++; if (Owner !== 1'(exp_own)) begin errors++; $display("FAIL rr_owner_%0d: got %b expected %0d", g, Owner, exp_own); end
    end
    step; drive(0, 0, 0, 0, 8'h00, 8'h00); drive(1, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    checks++; if (who !== exp_own) begin errors++; $display("FAIL rr_last_done: got %0d expected %0d", who, exp_own); end
  endtask

  task automatic test_watchdog;
    int who, t, td, tt; logic [7:0] rx; exp_t e; bit early;
    step; drive(1, 1, 1, 0, 8'hD0, 8'h00);
    wait_ack(10, who, t);
    checks++; if (who !== 1) begin errors++; $display("FAIL wd_ack1: got %0d expected 1", who); end
    exp_q.push_back('{req: 2'd1, rxd: rom(8'hD0), chk: 1'b1});
    step; drive(1, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req) || rx !== e.rxd) begin errors++; $display("FAIL wd_done1: got %0d/%h expected %0d/%h", who, rx, e.req, e.rxd); end
    step; drive(0, 1, 0, 1, 8'h30, 8'h55);
    tt = -1; early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Req0_ack) early = 1'b1;
      if (Timeout) begin tt = cyc; break; end
    end
    checks++; if (tt - td !== 20) begin errors++; $display("FAIL wd_timeout_lat: got %0d expected 20", tt - td); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL wd_req0_early: got %b expected 0", early); end
    @(negedge Clk);
    checks++; if ({Busy, Req0_ack, Timeout} !== 3'b010) begin errors++; $display("FAIL wd_after: got %b expected 010", {Busy, Req0_ack, Timeout}); end
    exp_q.push_back('{req: 2'd0, rxd: 8'h00, chk: 1'b0});
    step; drive(0, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL wd_done0: got %0d expected %0d", who, e.req); end
  endtask

  task automatic test_stray;
    int who, t, td; logic [7:0] rx; exp_t e; bit bad;
    step; stray_cnt++; bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Req0_done || Req1_done || Busy || Rxd !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stray_idle: got %b expected 0", bad); end
    step; drive(0, 1, 1, 0, 8'h40, 8'h00);
    wait_ack(10, who, t);
    exp_q.push_back('{req: 2'd0, rxd: rom(8'h40), chk: 1'b1});
    step; drive(0, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req) || rx !== e.rxd) begin errors++; $display("FAIL stray_setup: got %0d/%h expected %0d/%h", who, rx, e.req, e.rxd); end
    step; stray_cnt++; bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Req0_done || Req1_done || !Busy || Owner) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stray_hold: got %b expected 0", bad); end
    step; drive(0, 1, 0, 1, 8'h41, 8'h99);
    wait_ack(3, who, t);
    checks++; if (who !== 0) begin errors++; $display("FAIL stray_hold_ack: got %0d expected 0", who); end
    exp_q.push_back('{req: 2'd0, rxd: 8'h00, chk: 1'b0});
    step; drive(0, 0, 0, 0, 8'h00, 8'h00);
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL stray_final: got %0d expected %0d", who, e.req); end
  endtask

  task automatic test_reset_mid;
    int who, t, td; logic [7:0] rx; exp_t e; bit bad;
    step; drive(1, 1, 0, 1, 8'h77, 8'h11);
    wait_ack(10, who, t);
    step; drive(1, 0, 0, 0, 8'h00, 8'h00);
    step;
    checks++; if ({Busy, Owner} !== 2'b11) begin errors++; $display("FAIL rstmid_pre: got %b expected 11", {Busy, Owner}); end
    #2 Rst = 1'b1;
    #1;
    checks++; if ({Busy, Owner, I2C_start, I2C_rdwr, I2C_last, Timeout, Req0_ack, Req1_ack, Req0_done, Req1_done, I2C_addr, I2C_txd, Rxd} !== 34'h0) begin
      errors++; $display("FAIL rstmid_async: got %h expected 0", {Busy, Owner, I2C_start, I2C_rdwr, I2C_last, Timeout, Req0_ack, Req1_ack, Req0_done, Req1_done, I2C_addr, I2C_txd, Rxd}); end
    drive(0, 1, 0, 1, 8'h88, 8'h22);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Req0_ack || Req1_ack || Req0_done || Req1_done || Busy) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_held: got %b expected 0", bad); end
    step; Rst = 1'b0;
    @(negedge Clk);
    checks++; if (Req0_ack !== 1'b1) begin errors++; $display("FAIL rstmid_first_ack: got %b expected 1", Req0_ack); end
    exp_q.push_back('{req: 2'd0, rxd: 8'h00, chk: 1'b0});
    step; drive(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge Clk);
    checks++; if ({I2C_start, I2C_addr, I2C_txd} !== {1'b1, 8'h88, 8'h22}) begin
      errors++; $display("FAIL rstmid_issue: got %h expected %h", {I2C_start, I2C_addr, I2C_txd}, {1'b1, 8'h88, 8'h22}); end
    wait_done(20, who, rx, td);
    e = exp_q.pop_front();
    checks++; if (who !== int'(e.req)) begin errors++; $display("FAIL rstmid_done: got %0d expected %0d", who, e.req); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_lock;
    test_contention;
    test_watchdog;
    test_stray;
    test_reset_mid;
    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
